// File: rtl/cache_meta_array.sv
// cache_meta_array: per-set valid, dirty and tree pseudo-LRU metadata with a whole-array flush sweeper.
// Dirty tracking is only built when the macro CACHE_META_DIRTY_EN is defined.
module cache_meta_array #(
  parameter int WAYS  = 2,
  parameter int SETS  = 32,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] index,
  output logic [WAYS-1:0]  valid,
  output logic [WAYS-1:0]  dirty,
  output logic [WAY_W-1:0] victim,
  input  logic             fill_en,
  input  logic [WAY_W-1:0] fill_way,
  input  logic             fill_dirty,
  input  logic             touch_en,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             mark_dirty_en,
  input  logic [WAY_W-1:0] mark_dirty_way,
  input  logic             inv_en,
  input  logic [WAY_W-1:0] inv_way,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
  logic [SETS-1:0][WAYS-2:0] plru_q, plru_d;
  logic [WAYS-1:0]           valid_row;
  logic [WAYS-2:0]           plru_row;
  logic [WAY_W-1:0]          tree_way, victim_c, node;
  logic                      idle;

  // Point every node on the path of 'way' away from it, root first.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] cur,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0]  r;
    logic [WAY_W-1:0] n;
    logic [WAY_W-1:0] w;
    logic             b;
    r = cur;
    n = '0;
    w = way;
    for (int l = 0; l < WAY_W; l++) begin
      b    = w[WAY_W-1];
      r[n] = ~b;
      n    = WAY_W'((32'(n) << 1) + 32'd1 + 32'(b));
      w    = w << 1;
    end
    return r;
  endfunction

  assign idle       = (state_q == ST_IDLE);
  assign flush_busy = (state_q == ST_SWEEP);
  assign flush_done = (state_q == ST_DONE);
  assign valid_row  = valid_q[index];
  assign plru_row   = plru_q[index];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Tree walk gives the pLRU choice; any invalid way overrides it, lowest first.
  always_comb begin
    node     = '0;
    tree_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      tree_way = WAY_W'({tree_way, plru_row[node]});
      node     = WAY_W'((32'(node) << 1) + 32'd1 + 32'(plru_row[node]));
    end
    victim_c = tree_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_row[w]) victim_c = WAY_W'(w);
    end
  end

  assign valid  = idle ? valid_row : '0;
  assign victim = idle ? victim_c : '0;

  // Later assignments win, which yields inv > fill on a shared way.
  always_comb begin
    valid_d = valid_q;
    plru_d  = plru_q;
    if (state_q == ST_SWEEP) begin
      valid_d[cnt_q] = '0;
      plru_d[cnt_q]  = '0;
    end else if (idle) begin
      if (fill_en) valid_d[index][fill_way] = 1'b1;
      if (inv_en)  valid_d[index][inv_way]  = 1'b0;
      if (fill_en)       plru_d[index] = plru_touch(plru_q[index], fill_way);
      else if (touch_en) plru_d[index] = plru_touch(plru_q[index], touch_way);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      plru_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      plru_q  <= plru_d;
    end
  end

`ifdef CACHE_META_DIRTY_EN
  logic [SETS-1:0][WAYS-1:0] dirty_q, dirty_d;

  // A store hit only marks a way that is already valid.
  always_comb begin
    dirty_d = dirty_q;
    if (state_q == ST_SWEEP) begin
      dirty_d[cnt_q] = '0;
    end else if (idle) begin
      if (mark_dirty_en && valid_q[index][mark_dirty_way]) dirty_d[index][mark_dirty_way] = 1'b1;
      if (fill_en) dirty_d[index][fill_way] = fill_dirty;
      if (inv_en)  dirty_d[index][inv_way]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dirty_q <= '0;
    else       dirty_q <= dirty_d;
  end

  assign dirty = idle ? dirty_q[index] : '0;
`else
  logic unused_dirty_inputs;
  assign unused_dirty_inputs = ^{fill_dirty, mark_dirty_en, mark_dirty_way};
  assign dirty = '0;
`endif

endmodule

// File: tb/tb_cache_meta_array.sv
// tb_cache_meta_array: directed checks of a 2-way/32-set and a 4-way/16-set metadata array.
module tb_cache_meta_array;

`ifdef CACHE_META_DIRTY_EN
  localparam bit DIRTY_ON = 1'b1;
`else
  localparam bit DIRTY_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [4:0] idx2;
  logic [1:0] valid2, dirty2;
  logic       victim2;
  logic       fill_en2, fill_way2, fill_dirty2, touch_en2, touch_way2;
  logic       mde2, mdw2, inv_en2, inv_way2, flush_req2, busy2, done2;

  logic [3:0] idx4;
  logic [3:0] valid4, dirty4;
  logic [1:0] victim4;
  logic       fill_en4, fill_dirty4, touch_en4, mde4, inv_en4, flush_req4, busy4, done4;
  logic [1:0] fill_way4, touch_way4, mdw4, inv_way4;

  int total = 0;
  int bad   = 0;

  cache_meta_array #(.WAYS(2), .SETS(32)) dut2 (
    .clk(clk), .rstn(rstn), .index(idx2), .valid(valid2), .dirty(dirty2), .victim(victim2),
    .fill_en(fill_en2), .fill_way(fill_way2), .fill_dirty(fill_dirty2),
    .touch_en(touch_en2), .touch_way(touch_way2),
    .mark_dirty_en(mde2), .mark_dirty_way(mdw2), .inv_en(inv_en2), .inv_way(inv_way2),
    .flush_req(flush_req2), .flush_busy(busy2), .flush_done(done2));

  cache_meta_array #(.WAYS(4), .SETS(16)) dut4 (
    .clk(clk), .rstn(rstn), .index(idx4), .valid(valid4), .dirty(dirty4), .victim(victim4),
    .fill_en(fill_en4), .fill_way(fill_way4), .fill_dirty(fill_dirty4),
    .touch_en(touch_en4), .touch_way(touch_way4),
    .mark_dirty_en(mde4), .mark_dirty_way(mdw4), .inv_en(inv_en4), .inv_way(inv_way4),
    .flush_req(flush_req4), .flush_busy(busy4), .flush_done(done4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ops();
    fill_en2 = 0; fill_way2 = 0; fill_dirty2 = 0; touch_en2 = 0; touch_way2 = 0;
    mde2 = 0; mdw2 = 0; inv_en2 = 0; inv_way2 = 0; flush_req2 = 0;
    fill_en4 = 0; fill_way4 = 0; fill_dirty4 = 0; touch_en4 = 0; touch_way4 = 0;
    mde4 = 0; mdw4 = 0; inv_en4 = 0; inv_way4 = 0; flush_req4 = 0;
  endtask

  task automatic fill2(input logic [4:0] set, input logic way, input logic fd);
    clr_ops(); idx2 = set; fill_en2 = 1; fill_way2 = way; fill_dirty2 = fd;
    step(); clr_ops();
  endtask

  task automatic test_reset();
    clr_ops(); idx2 = 5'd5; idx4 = 4'd0; rstn = 0;
    step(); step();
    total++; if (valid2 !== 2'b00) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=00", valid2); end
    total++; if (dirty2 !== 2'b00) begin bad++; $display("[TB] FAIL reset_dirty got=%b exp=00", dirty2); end
    total++; if (victim2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_victim got=%b exp=0", victim2); end
    total++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush busy=%b done=%b exp=0/0", busy2, done2); end
    total++; if (valid4 !== 4'b0000) begin bad++; $display("[TB] FAIL reset_valid4 got=%b exp=0000", valid4); end
    rstn = 1; step();
  endtask

  task automatic test_plru2();
    fill2(5'd3, 1'b0, 1'b0);
    fill2(5'd3, 1'b1, 1'b0);
    idx2 = 5'd3; #1;
    total++; if (valid2 !== 2'b11) begin bad++; $display("[TB] FAIL plru2_valid got=%b exp=11", valid2); end
    total++; if (victim2 !== 1'b0) begin bad++; $display("[TB] FAIL plru2_after_fill got=%b exp=0", victim2); end
    touch_en2 = 1; touch_way2 = 0; step(); clr_ops();
    total++; if (victim2 !== 1'b1) begin bad++; $display("[TB] FAIL plru2_touch0 got=%b exp=1", victim2); end
    touch_en2 = 1; touch_way2 = 1; step(); clr_ops();
    total++; if (victim2 !== 1'b0) begin bad++; $display("[TB] FAIL plru2_touch1 got=%b exp=0", victim2); end
    // fill wins over touch as the pLRU access
    fill2(5'd12, 1'b0, 1'b0);
    fill2(5'd12, 1'b1, 1'b0);
    idx2 = 5'd12; fill_en2 = 1; fill_way2 = 1; touch_en2 = 1; touch_way2 = 0;
    step(); clr_ops();
    total++; if (victim2 !== 1'b0) begin bad++; $display("[TB] FAIL plru2_fill_over_touch got=%b exp=0", victim2); end
  endtask

  task automatic test_plru4();
    logic [1:0] ways [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    idx4 = 4'd7;
    for (int i = 0; i < 4; i++) begin
      clr_ops(); fill_en4 = 1; fill_way4 = ways[i]; step(); clr_ops();
      if (i == 0) begin
        total++; if (victim4 !== 2'd1) begin bad++; $display("[TB] FAIL plru4_lowest_invalid got=%0d exp=1", victim4); end
      end
    end
    total++; if (valid4 !== 4'b1111) begin bad++; $display("[TB] FAIL plru4_valid got=%b exp=1111", valid4); end
    total++; if (victim4 !== 2'd0) begin bad++; $display("[TB] FAIL plru4_after_fills got=%0d exp=0", victim4); end
    touch_en4 = 1; touch_way4 = 2'd0; step(); clr_ops();
    total++; if (victim4 !== 2'd2) begin bad++; $display("[TB] FAIL plru4_touch0 got=%0d exp=2", victim4); end
    inv_en4 = 1; inv_way4 = 2'd3; step(); clr_ops();
    total++; if (victim4 !== 2'd3) begin bad++; $display("[TB] FAIL plru4_inv3_victim got=%0d exp=3", victim4); end
    total++; if (valid4 !== 4'b0111) begin bad++; $display("[TB] FAIL plru4_inv3_valid got=%b exp=0111", valid4); end
  endtask

  task automatic test_same_cycle();
    fill2(5'd9, 1'b1, 1'b0);
    idx2 = 5'd9; #1;
    total++; if (valid2 !== 2'b10) begin bad++; $display("[TB] FAIL same_setup got=%b exp=10", valid2); end
    inv_en2 = 1; inv_way2 = 1; fill_en2 = 1; fill_way2 = 1; fill_dirty2 = 1; step(); clr_ops();
    total++; if (valid2 !== 2'b00 || dirty2 !== 2'b00) begin bad++; $display("[TB] FAIL inv_over_fill valid=%b dirty=%b exp=00/00", valid2, dirty2); end
    mde2 = 1; mdw2 = 0; step(); clr_ops();
    total++; if (dirty2 !== 2'b00) begin bad++; $display("[TB] FAIL mark_invalid got=%b exp=00", dirty2); end
    fill2(5'd9, 1'b0, 1'b0);
    idx2 = 5'd9; mde2 = 1; mdw2 = 0; step(); clr_ops();
    total++; if (dirty2 !== (DIRTY_ON ? 2'b01 : 2'b00)) begin bad++; $display("[TB] FAIL store_hit got=%b exp=%b", dirty2, DIRTY_ON ? 2'b01 : 2'b00); end
    fill_en2 = 1; fill_way2 = 1; fill_dirty2 = 1; inv_en2 = 1; inv_way2 = 0; step(); clr_ops();
    total++; if (valid2 !== 2'b10) begin bad++; $display("[TB] FAIL diff_ways_valid got=%b exp=10", valid2); end
    total++; if (dirty2 !== (DIRTY_ON ? 2'b10 : 2'b00)) begin bad++; $display("[TB] FAIL diff_ways_dirty got=%b exp=%b", dirty2, DIRTY_ON ? 2'b10 : 2'b00); end
  endtask

  task automatic test_flush();
    fill2(5'd0, 1'b0, 1'b0);
    fill2(5'd31, 1'b1, 1'b1);
    idx2 = 5'd31; flush_req2 = 1; step(); clr_ops();
    for (int k = 1; k <= 32; k++) begin
      total++; if (busy2 !== 1'b1 || done2 !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy_k%0d busy=%b done=%b exp=1/0", k, busy2, done2); end
      if (k == 1) begin
        total++; if (valid2 !== 2'b00 || victim2 !== 1'b0) begin bad++; $display("[TB] FAIL flush_forced valid=%b victim=%b exp=00/0", valid2, victim2); end
      end
      if (k == 5) flush_req2 = 1;
      if (k == 10) begin idx2 = 5'd0; fill_en2 = 1; fill_way2 = 1; end
      step(); clr_ops();
    end
    total++; if (done2 !== 1'b1 || busy2 !== 1'b0) begin bad++; $display("[TB] FAIL flush_done_pulse done=%b busy=%b exp=1/0", done2, busy2); end
    step();
    total++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("[TB] FAIL flush_idle done=%b busy=%b exp=0/0", done2, busy2); end
    idx2 = 5'd0; #1;
    total++; if (valid2 !== 2'b00) begin bad++; $display("[TB] FAIL flush_set0 got=%b exp=00", valid2); end
    idx2 = 5'd31; #1;
    total++; if (valid2 !== 2'b00 || dirty2 !== 2'b00) begin bad++; $display("[TB] FAIL flush_set31 valid=%b dirty=%b exp=00/00", valid2, dirty2); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    flush_req2 = 1; step(); clr_ops();
    for (int k = 1; k <= 32; k++) step();
    total++; if (done2 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_done got=%b exp=1", done2); end
    flush_req2 = 1; step();
    total++; if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL b2b_req_in_done busy=%b exp=0", busy2); end
    step(); clr_ops();
    total++; if (busy2 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_req_accepted busy=%b exp=1", busy2); end
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (done2 === 1'b1) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL b2b_second_done timeout got=0 exp=1"); end
    step();
  endtask

  task automatic test_reset_mid_flush();
    bit seen;
    fill2(5'd20, 1'b0, 1'b1);
    idx2 = 5'd20; flush_req2 = 1; step(); clr_ops();
    for (int k = 1; k < 10; k++) step();
    rstn = 0; #1;
    total++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin bad++; $display("[TB] FAIL midrst_flags busy=%b done=%b exp=0/0", busy2, done2); end
    step(); rstn = 1;
    #1;
    total++; if (valid2 !== 2'b00 || dirty2 !== 2'b00) begin bad++; $display("[TB] FAIL midrst_set20 valid=%b dirty=%b exp=00/00", valid2, dirty2); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done2 === 1'b1 || busy2 === 1'b1) seen = 1;
    end
    total++; if (seen) begin bad++; $display("[TB] FAIL midrst_no_done got=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    test_plru2();
    test_plru4();
    test_same_cycle();
    test_flush();
    test_back_to_back();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_meta_array.md
# cache_meta_array

Per-set cache metadata store for the D-cache: valid bits, optional dirty bits and tree pseudo-LRU replacement state for `WAYS` ways across `SETS` sets. It generalises the fixed 2-way/32-set valid array to any power-of-two way count. It adds invalidate, dirty tracking, victim selection and a multi-cycle flush sequencer. It sits beside the tag/data arrays and is driven by the D-cache control FSM.

## Interface
- `WAYS`, 2: associativity; power of two, 2..8.
- `SETS`, 32: number of sets; power of two, 2..256.
- `IDX_W`, $clog2(SETS): set index width (derived).
- `WAY_W`, $clog2(WAYS): way select width (derived).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `index`  in  IDX_W  set used by lookups and by all write ops this cycle.
- `valid`  out  WAYS  valid bits of set `index`, combinational.
- `dirty`  out  WAYS  dirty bits of set `index`, combinational.
- `victim`  out  WAY_W  way to replace in set `index`, combinational.
- `fill_en`  in  1  mark `fill_way` valid; also counts as an access for pLRU.
- `fill_way`  in  WAY_W  way being filled.
- `fill_dirty`  in  1  initial dirty value for the filled way.
- `touch_en`  in  1  hit access; update pLRU toward `touch_way`.
- `touch_way`  in  WAY_W  way hit.
- `mark_dirty_en`  in  1  set dirty on `mark_dirty_way` (store hit).
- `mark_dirty_way`  in  WAY_W  way to mark dirty.
- `inv_en`  in  1  clear valid and dirty of `inv_way`.
- `inv_way`  in  WAY_W  way to invalidate.
- `flush_req`  in  1  start whole-array flush; sampled only when idle.
- `flush_busy`  out  1  flush sweep in progress.
- `flush_done`  out  1  one-cycle pulse after the last set is cleared.

## Operation
- **Reset.** While `rstn`=0, all valid, dirty and pLRU bits are 0, the flush FSM is IDLE, the sweep counter is 0, and `flush_busy`=`flush_done`=0. Consequently `valid`=0, `dirty`=0 and `victim`=0.
- **Victim selection.** If any way in the set is invalid, `victim` is the lowest-numbered invalid way. Otherwise `victim` is taken from the pLRU tree.
- **pLRU tree.**
  - Each set holds WAYS-1 node bits. Node bit 0 points to the lower half, 1 to the upper half.
  - The victim is found by walking from the root.
  - On an access to way w, every node on w's path is set to point away from w. For WAYS=2 this gives: bit = ~w.
- **Write ops.** All write ops act on set `index` at the clock edge, and several may occur in the same cycle.
  - When ops target the same way, priority is inv > fill > mark_dirty.
  - Ops on different ways in one cycle all take effect.
- **pLRU source.** When `fill_en` is asserted, `fill_way` is the access used for the pLRU update. Otherwise `touch_way` is used when `touch_en` is asserted. `inv_en` does not change pLRU.
- **`mark_dirty_en` on an invalid way** is ignored.
- **Flush FSM.**
  - IDLE: when `flush_req`=1, go to SWEEP with counter = 0.
  - SWEEP: each cycle, clear valid, dirty and pLRU of set `counter`, then increment the counter. On clearing set SETS-1, go to DONE.
  - DONE: `flush_done`=1 for one cycle, then return to IDLE.
- **During SWEEP or DONE:**
  - `flush_req` is ignored.
  - All write-op inputs are ignored.
  - `valid` and `dirty` are forced to 0, and `victim`=0.
- **Reset mid-flush** returns to IDLE with everything cleared; no `flush_done` pulse.

## Timing
- Lookup is combinational from `index`, so the read latency is 0.
- A write at edge N is visible on the outputs from cycle N+1.
- `flush_req` high in cycle t (IDLE) gives:
  - `flush_busy`=1 in cycles t+1 .. t+SETS;
  - `flush_done`=1 in cycle t+SETS+1;
  - new requests accepted from cycle t+SETS+1 (DONE excluded) — more precisely, from t+SETS+2.
- `flush_busy` is low in DONE.
- Flush total: SETS+1 cycles from request to done pulse.

## Configuration
- `CACHE_META_DIRTY_EN` defined: per-way dirty bits are implemented as described above.
- `CACHE_META_DIRTY_EN` undefined:
  - no dirty storage;
  - `dirty` is tied to 0;
  - `fill_dirty` and `mark_dirty_en` are ignored;
  - all other behaviour is identical.

## Test plan
- Reset, then read index 5 (WAYS=2) -> `valid`=2'b00, `dirty`=2'b00, `victim`=0.
- Fill way 0 at set 3, then fill way 1 at set 3 -> `valid`=2'b11. Then touch way 0 -> `victim`=1; touch way 1 -> `victim`=0.
- WAYS=4, set 7:
  - fill ways 0,1,2,3 in order -> `victim`=0;
  - touch way 0 -> `victim`=2;
  - inv way 3 -> `victim`=3 and `valid`=4'b0111.
- Same cycle at set 9 holding valid way 1: `inv_en` way 1 + `fill_en` way 1 with `fill_dirty`=1 -> way 1 invalid, dirty 0. Separately, `mark_dirty_en` on invalid way 0 -> `dirty`=0 (DIRTY_EN build).
- Fill sets 0 and 31, then pulse `flush_req` at cycle t -> `flush_busy` high for 32 cycles, `flush_done` pulse at t+33, all sets `valid`=0. A `fill_en` during busy has no effect.
- Assert `rstn`=0 at cycle t+10 of a flush -> outputs clear immediately and no `flush_done` appears. Rebuild with `CACHE_META_DIRTY_EN` undefined and repeat the store-hit case -> `dirty` stays 0.
